// File: rtl/wb_common_pkg.sv
// Wishbone definitions shared by the memory responder and the master BFM:
// cycle/burst type codes, operation codes and the burst next-address rule.
package wb_common_pkg;

   localparam int ADR_MAX = 64;

   typedef enum logic [2:0] {
      CTI_CLASSIC  = 3'b000,
      CTI_CONSTANT = 3'b001,
      CTI_INCR     = 3'b010,
      CTI_EOB      = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // Incrementing bursts step one word; wrapping bursts only carry within the
   // low log2(N)+adr_lsb bits so the address stays inside its N-beat block.
   function automatic logic [ADR_MAX-1:0] next_adr(
      input logic [ADR_MAX-1:0] adr,
      input logic [2:0]         cti,
      input logic [1:0]         bte,
      input int unsigned        adr_lsb
   );
      logic [ADR_MAX-1:0] inc;
      logic [ADR_MAX-1:0] mask;
      inc = adr + (ADR_MAX'(1) << adr_lsb);
      case (bte)
         BTE_WRAP4:  mask = (ADR_MAX'(4) << adr_lsb) - ADR_MAX'(1);
         BTE_WRAP8:  mask = (ADR_MAX'(8) << adr_lsb) - ADR_MAX'(1);
         BTE_WRAP16: mask = (ADR_MAX'(16) << adr_lsb) - ADR_MAX'(1);
         default:    mask = '1;
      endcase
      if (cti == CTI_INCR)
         next_adr = (adr & ~mask) | (inc & mask);
      else
         next_adr = adr;
   endfunction

endpackage

// File: rtl/wb_burst_addr.sv
// Combinational predictor of the next beat address of a Wishbone burst.
module wb_burst_addr
   import wb_common_pkg::*;
#(
   parameter int aw = 32,
   parameter int dw = 32
)(
   input  logic [aw-1:0] adr,
   input  logic [2:0]    cti,
   input  logic [1:0]    bte,
   output logic [aw-1:0] adr_nxt
);

   localparam int unsigned ADR_LSB = $clog2(dw / 8);

   assign adr_nxt = aw'(next_adr(ADR_MAX'(adr), cti, bte, ADR_LSB));

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 registered-feedback memory slave: classic and burst cycles,
// programmable wait states, byte enables and out-of-range error response.
module wb_mem_responder
   import wb_common_pkg::*;
#(
   parameter int            aw          = 32,
   parameter int            dw          = 32,
   parameter int            MEM_WORDS   = 256,
   parameter int            WAIT_STATES = 0,
   parameter logic [aw-1:0] BASE_ADDR   = '0
)(
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic [aw-1:0]   wb_adr_i,
   input  logic [dw-1:0]   wb_dat_i,
   input  logic [dw/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [dw-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o
);

   localparam int            SEL_W     = dw / 8;
   localparam int            ADR_LSB   = $clog2(SEL_W);
   localparam int            IDX_W     = $clog2(MEM_WORDS);
   localparam logic [aw:0]   MEM_BYTES = (aw + 1)'(MEM_WORDS * SEL_W);
   localparam logic [3:0]    WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, CLASSIC_ACK, BURST} state_e;

   state_e          state_q, state_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;
   logic            we_q;
   logic            first_beat_q;
   logic [aw-1:0]   pred_adr_q;
   logic [dw-1:0]   mem [MEM_WORDS];

   logic            req, beat, burst_cti, in_range, we_changed, bad_beat, mem_we;
   logic [aw-1:0]   beat_adr, offset, adr_nxt;
   logic [IDX_W-1:0] idx;

   assign req       = wb_cyc_i & wb_stb_i;
   assign burst_cti = (wb_cti_i == CTI_CONSTANT) || (wb_cti_i == CTI_INCR);

   // After the first burst beat the master's address is ignored in favour of
   // the prediction, so data is ready with each ack without a bubble.
   assign beat_adr = first_beat_q ? wb_adr_i : pred_adr_q;
   assign offset   = beat_adr - BASE_ADDR;
   assign in_range = (beat_adr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
   assign idx      = offset[ADR_LSB +: IDX_W];

   assign we_changed = (state_q == BURST) && (wb_we_i != we_q);
   assign beat       = req && ((state_q == CLASSIC_ACK) || (state_q == BURST));
   assign bad_beat   = !in_range || we_changed;
   assign wb_ack_o   = beat && !bad_beat;
   assign wb_err_o   = beat && bad_beat;
   assign wb_rty_o   = 1'b0;
   assign wb_dat_o   = wb_ack_o ? mem[idx] : '0;
   assign mem_we     = wb_ack_o && (wb_we_i == OP_WRITE);

   wb_burst_addr #(
      .aw (aw),
      .dw (dw)
   ) u_burst_addr (
      .adr     (beat_adr),
      .cti     (wb_cti_i),
      .bte     (wb_bte_i),
      .adr_nxt (adr_nxt)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_INIT == 4'd0) begin
                  state_d = burst_cti ? BURST : CLASSIC_ACK;
               end else begin
                  state_d    = WAIT;
                  wait_cnt_d = WAIT_INIT;
               end
            end
         end
         // Leave when the decremented count reaches zero, giving N+1 cycles
         // from request sample to first ack.
         WAIT: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q <= 4'd1)
               state_d = burst_cti ? BURST : CLASSIC_ACK;
         end
         CLASSIC_ACK: state_d = IDLE;
         BURST: begin
            if (wb_err_o || (wb_ack_o && (wb_cti_i == CTI_EOB)))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!wb_cyc_i) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, regardless of statement order.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         we_q         <= 1'b0;
         first_beat_q <= 1'b1;
         pred_adr_q   <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if ((state_q == IDLE) && req)
            we_q <= wb_we_i;
         if (state_q != BURST)
            first_beat_q <= 1'b1;
         else if (beat)
            first_beat_q <= 1'b0;
         if ((state_q == BURST) && beat)
            pred_adr_q <= adr_nxt;
      end
   end

   // NOTE: the storage array has no reset; clearing it would turn the RAM
   // into a flop bank. Reset still blocks writes since it forces IDLE.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < SEL_W; k++) begin
            if (wb_sel_i[k])
               mem[idx][k*8 +: 8] <= wb_dat_i[k*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed self-checking bench for wb_mem_responder with two wait states.
module tb_wb_mem_responder;

   localparam logic [31:0] LAT = 32'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] adr, dat, dat_o;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, err, rty;
   logic [2:0]  cti;
   logic [1:0]  bte;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] vec [8];

   always #5 clk = ~clk;

   wb_mem_responder #(
      .aw          (32),
      .dw          (32),
      .MEM_WORDS   (256),
      .WAIT_STATES (2),
      .BASE_ADDR   (32'h0)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wb_adr_i  (adr),
      .wb_dat_i  (dat),
      .wb_sel_i  (sel),
      .wb_we_i   (we),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .wb_cti_i  (cti),
      .wb_bte_i  (bte),
      .wb_dat_o  (dat_o),
      .wb_ack_o  (ack),
      .wb_err_o  (err),
      .wb_rty_o  (rty)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
      sel = 4'h0; cti = 3'b000; bte = 2'b00;
   endtask

   // One classic cycle; also samples the cycle after the termination with
   // stb still high to catch a repeated ack.
   task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int lat,
                          output logic [2:0] term);
      logic ga, ge;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      cti = 3'b000; bte = 2'b00;
      lat = -1; rd = '0; ga = 1'b0; ge = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (ack || err) begin
            lat = c; rd = dat_o; ga = ack; ge = err;
            break;
         end
      end
      @(negedge clk);
      term = {ack || err, ge, ga};
      idle_bus();
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      logic [31:0] r; int lat; logic [2:0] t;
      classic(1'b1, a, d, s, r, lat, t);
      check({tag, " latency"}, 32'(lat), LAT);
      check({tag, " reack/err/ack"}, 32'(t), 32'd1);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r; int lat; logic [2:0] t;
      classic(1'b0, a, 32'h0, 4'hF, r, lat, t);
      check({tag, " latency"}, 32'(lat), LAT);
      check({tag, " reack/err/ack"}, 32'(t), 32'd1);
      check({tag, " data"}, r, exp);
   endtask

   task automatic oor(input string tag, input logic w, input logic [31:0] a);
      logic [31:0] r; int lat; logic [2:0] t;
      classic(w, a, 32'h1234_5678, 4'hF, r, lat, t);
      check({tag, " latency"}, 32'(lat), LAT);
      check({tag, " reack/err/ack"}, 32'(t), 32'd2);
      check({tag, " data"}, r, 32'h0);
   endtask

   // Burst of n beats using vec[] as write data or expected read data; cyc
   // drops after beat stop_after when that is below n, otherwise the last
   // beat carries end-of-burst. The bench only generates linear and wrap4.
   task automatic burst(input string tag, input logic w, input logic [31:0] a,
                        input logic [1:0] b, input int n, input int stop_after);
      logic [31:0] cur;
      int c;
      cur = a;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = cur; dat = vec[0]; sel = 4'hF;
      cti = (n == 1) ? 3'b111 : 3'b010; bte = b;
      for (c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (ack || err) break;
      end
      check({tag, " first latency"}, 32'(c), LAT);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            cur = (b == 2'b00) ? cur + 32'd4 : ((cur & ~32'hF) | ((cur + 32'd4) & 32'hF));
            adr = cur; dat = vec[i];
            cti = (i == n - 1) ? 3'b111 : 3'b010;
            @(negedge clk);
         end
         check($sformatf("%s beat%0d err/ack", tag, i), {30'd0, err, ack}, 32'd1);
         if (!w) check($sformatf("%s beat%0d data", tag, i), dat_o, vec[i]);
         if (i + 1 == stop_after) begin
            @(posedge clk); #1;
            idle_bus();
            return;
         end
      end
      @(posedge clk); #1;
      cti = 3'b000;
      @(negedge clk);
      check({tag, " after end err/ack"}, {30'd0, err, ack}, 32'd0);
      idle_bus();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c;
      idle_bus();
      cyc = 1'b1; stb = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset err/ack", {30'd0, err, ack}, 32'd0);
      check("reset dat_o", dat_o, 32'h0);
      check("rty tied low", {31'd0, rty}, 32'd0);
      idle_bus();
      @(negedge clk);
      rst_n = 1'b1;

      wr("classic wr", 32'h10, 32'hDEAD_BEEF, 4'hF);
      rd("classic rd", 32'h10, 32'hDEAD_BEEF);

      wr("byte pre", 32'h20, 32'h1122_3344, 4'hF);
      wr("byte wr", 32'h20, 32'h00AA_0000, 4'b0100);
      rd("byte rd", 32'h20, 32'h11AA_3344);

      wr("fill 10", 32'h10, 32'hA000_0001, 4'hF);
      wr("fill 14", 32'h14, 32'hB000_0002, 4'hF);
      wr("fill 18", 32'h18, 32'hC000_0003, 4'hF);
      wr("fill 1c", 32'h1C, 32'hD000_0004, 4'hF);
      vec = '{32'hC000_0003, 32'hD000_0004, 32'hA000_0001, 32'hB000_0002,
              32'h0, 32'h0, 32'h0, 32'h0};
      burst("wrap4 @18", 1'b0, 32'h18, 2'b01, 4, 0);
      vec = '{32'hD000_0004, 32'hA000_0001, 32'hB000_0002, 32'hC000_0003,
              32'h0, 32'h0, 32'h0, 32'h0};
      burst("wrap4 @1c", 1'b0, 32'h1C, 2'b01, 4, 0);

      wr("alias pre", 32'h0, 32'h5555_AAAA, 4'hF);
      oor("oor rd", 1'b0, 32'h400);
      oor("oor wr", 1'b1, 32'h400);
      rd("alias rd", 32'h0, 32'h5555_AAAA);

      wr("lin pre", 32'h4C, 32'h0, 4'hF);
      for (int i = 0; i < 8; i++) vec[i] = 32'h5000_0000 | 32'(i);
      burst("lin wr", 1'b1, 32'h40, 2'b00, 8, 3);
      rd("lin rd0", 32'h40, 32'h5000_0000);
      rd("lin rd1", 32'h44, 32'h5000_0001);
      rd("lin rd2", 32'h48, 32'h5000_0002);
      rd("lin rd3", 32'h4C, 32'h0);

      wr("rst pre0", 32'h80, 32'h0, 4'hF);
      wr("rst pre1", 32'h84, 32'h0, 4'hF);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; dat = 32'h6000_0000;
      sel = 4'hF; cti = 3'b010; bte = 2'b00;
      for (c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (ack || err) break;
      end
      check("rst burst latency", 32'(c), LAT);
      @(posedge clk); #1;
      adr = 32'h84; dat = 32'h6000_0001;
      @(negedge clk);
      check("rst beat1 err/ack", {30'd0, err, ack}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst abort err/ack", {30'd0, err, ack}, 32'd0);
      check("rst abort dat_o", dat_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_bus();
      rd("rst rd 84", 32'h84, 32'h0);
      rd("rst rd 80", 32'h80, 32'h6000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
